// File: rtl/uart_tx_scheduler_if.sv
// Client + TxUART side bundle of the uart_tx_scheduler.
// master = scheduler, slave = requesters / UART wrapper.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0][7:0] data;
    logic [NUM_REQ-1:0]      ack;
    logic                    cfg_req;
    logic [7:0]              cfg_data;
    logic                    cfg_ack;
    logic                    send;
    logic                    conf;
    logic [7:0]              dpin;
    logic                    busy;
    logic                    active;
    logic [GW-1:0]           grant_id;
    logic                    err;

    modport master (
        input  req, data, cfg_req, cfg_data, busy,
        output ack, cfg_ack, send, conf, dpin, active, grant_id, err
    );

    modport slave (
        output req, data, cfg_req, cfg_data, busy,
        input  ack, cfg_ack, send, conf, dpin, active, grant_id, err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one TxUART between NUM_REQ byte requesters and a config port.
// Optional ISSUE timeout abort enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                 clk,
    input logic                 rst,
    uart_tx_scheduler_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [GW-1:0]      gnt_q, gnt_d;
    logic               send_q, send_d;
    logic               conf_q, conf_d;
    logic               active_q, active_d;
    logic               cfg_ack_q, cfg_ack_d;
    logic [7:0]         dpin_q, dpin_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;

    logic               pick_vld;
    logic [GW-1:0]      pick_idx;
    logic [GW:0]        cand;

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          tmo_hit;
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
`endif

    // Scan from ptr+NUM_REQ down to ptr+1 so the nearest set request after ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = {1'b0, ptr_q} + (GW+1)'(off);
            if (cand >= (GW+1)'(NUM_REQ))
                cand = cand - (GW+1)'(NUM_REQ);
            if (bus.req[cand[GW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        send_d    = send_q;
        conf_d    = conf_q;
        dpin_d    = dpin_q;
        active_d  = active_q;
        ack_d     = '0;
        cfg_ack_d = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
        err_d     = 1'b0;
        tmo_d     = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                // A still-busy UART holds off every grant, config included.
                if (!bus.busy && (bus.cfg_req || pick_vld)) begin
                    state_d  = ISSUE;
                    send_d   = 1'b1;
                    active_d = 1'b1;
`ifdef UART_SCHED_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                    if (bus.cfg_req) begin
                        conf_d = 1'b1;
                        dpin_d = bus.cfg_data;
                    end else begin
                        conf_d = 1'b0;
                        dpin_d = bus.data[pick_idx];
                        gnt_d  = pick_idx;
                    end
                end
            end
            ISSUE: begin
                if (bus.busy) begin
                    state_d = WAIT_DONE;
                    send_d  = 1'b0;
                    if (conf_q) cfg_ack_d    = 1'b1;
                    else        ack_d[gnt_q] = 1'b1;
                end
`ifdef UART_SCHED_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d  = IDLE;
                    send_d   = 1'b0;
                    conf_d   = 1'b0;
                    active_d = 1'b0;
                    err_d    = 1'b1;
                    if (!conf_q) ptr_d = gnt_q;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.busy) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                    conf_d   = 1'b0;
                    if (!conf_q) ptr_d = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= GW'(NUM_REQ - 1);
            gnt_q     <= '0;
            send_q    <= 1'b0;
            conf_q    <= 1'b0;
            dpin_q    <= '0;
            active_q  <= 1'b0;
            ack_q     <= '0;
            cfg_ack_q <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            send_q    <= send_d;
            conf_q    <= conf_d;
            dpin_q    <= dpin_d;
            active_q  <= active_d;
            ack_q     <= ack_d;
            cfg_ack_q <= cfg_ack_d;
`ifdef UART_SCHED_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.send     = send_q;
    assign bus.conf     = conf_q;
    assign bus.dpin     = dpin_q;
    assign bus.active   = active_q;
    assign bus.grant_id = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.cfg_ack  = cfg_ack_q;
`ifdef UART_SCHED_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus a random run checked by a
// transaction-level rotating-priority model and a simple UART busy responder.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int GW  = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(N)) bus ();
  uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // inputs as the DUT saw them at the last edge
  logic                ap_rst, ap_cfg, ap_busy;
  logic [N-1:0]        ap_req;
  logic [7:0]          ap_cfgd;
  logic [N-1:0][7:0]   ap_data;
  logic                pv_send = 1'b0, pv_active = 1'b0;

  // UART responder
  bit uart_en = 1'b1;
  int u_phase = 0, u_cnt = 0, u_dly = 2, u_len = 4;

  // reference model state
  int         mptr = N-1;
  bit         pend = 0, pend_cfg = 0, pend_acked = 0;
  int         pend_idx = 0;
  logic [7:0] pend_byte = '0;
  int         n_grant = 0, n_dack = 0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int off = 1; off <= N; off++)
      if (r[(p + off) % N]) return (p + off) % N;
    return 0;
  endfunction

  task automatic cycle();
    logic [N-1:0] exp_ack;
    logic         exp_send;
    ap_rst = rst; ap_req = bus.req; ap_cfg = bus.cfg_req; ap_cfgd = bus.cfg_data;
    ap_busy = bus.busy; ap_data = bus.data;
    @(posedge clk); #1;
    if (ap_rst) begin
      mptr = N-1; pend = 0;
    end else begin
      if (!pv_active) begin
        exp_send = !ap_busy && (ap_cfg || (ap_req != '0));
        n_cmp++;
        if (bus.send !== exp_send) begin
          n_bad++; $display("FAIL grant_start: send=%b required %b (req=%b cfg=%b busy=%b)", bus.send, exp_send, ap_req, ap_cfg, ap_busy);
        end
      end
      if (bus.send === 1'b1 && !pv_send) begin
        n_cmp++;
        if (pend) begin n_bad++; $display("FAIL overlap: grant while previous transaction open"); end
        pend = 1; pend_acked = 0; pend_cfg = ap_cfg;
        if (ap_cfg) pend_byte = ap_cfgd;
        else begin
          pend_idx = rr_pick(ap_req, mptr);
          pend_byte = ap_data[pend_idx];
          n_cmp++;
          if (bus.grant_id !== GW'(pend_idx)) begin
            n_bad++; $display("FAIL grant_id: got %0d required %0d", bus.grant_id, pend_idx);
          end
        end
        n_cmp++;
        if (bus.conf !== pend_cfg || bus.dpin !== pend_byte || bus.active !== 1'b1) begin
          n_bad++; $display("FAIL grant_data: conf=%b dpin=%h active=%b required conf=%b dpin=%h active=1", bus.conf, bus.dpin, bus.active, pend_cfg, pend_byte);
        end
        n_grant++;
      end
      if (bus.ack !== '0 || bus.cfg_ack !== 1'b0) begin
        exp_ack = '0;
        if (pend && !pend_cfg) exp_ack[pend_idx] = 1'b1;
        n_cmp++;
        if (bus.ack !== exp_ack || bus.cfg_ack !== (pend && pend_cfg) || bus.dpin !== pend_byte || ap_busy !== 1'b1 || pend_acked) begin
          n_bad++; $display("FAIL ack: ack=%b cfg_ack=%b dpin=%h busy=%b required ack=%b cfg_ack=%b dpin=%h busy=1", bus.ack, bus.cfg_ack, bus.dpin, ap_busy, exp_ack, pend && pend_cfg, pend_byte);
        end
        pend_acked = 1; n_dack++;
      end
      if (pv_active && bus.active === 1'b0) begin
        n_cmp++;
        if (!(pend && (pend_acked || bus.err === 1'b1))) begin
          n_bad++; $display("FAIL completion: active fell with pend=%b acked=%b err=%b", pend, pend_acked, bus.err);
        end
        if (pend && !pend_cfg) mptr = pend_idx;
        pend = 0;
      end
    end
    pv_send = (bus.send === 1'b1); pv_active = (bus.active === 1'b1);
    if (uart_en) begin
      case (u_phase)
        0: if (bus.send === 1'b1) begin u_cnt = u_dly; u_phase = 1; end
        1: begin u_cnt--; if (u_cnt <= 0) begin bus.busy = 1'b1; u_cnt = u_len; u_phase = 2; end end
        default: begin u_cnt--; if (u_cnt <= 0) begin bus.busy = 1'b0; u_phase = 0; end end
      endcase
    end
  endtask

  // kind 0: send rises, 1: any ack/cfg_ack, 2: active falls
  task automatic wait_ev(input int kind, input int max, output bit ok);
    logic ps, pa;
    ok = 0;
    for (int t = 0; t < max && !ok; t++) begin
      ps = bus.send; pa = bus.active;
      cycle();
      case (kind)
        0: ok = (bus.send === 1'b1) && (ps !== 1'b1);
        1: ok = (bus.ack !== '0) || (bus.cfg_ack === 1'b1);
        default: ok = (pa === 1'b1) && (bus.active === 1'b0);
      endcase
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.cfg_req = 1'b0; bus.busy = 1'b0; u_phase = 0;
    cycle(); cycle();
    rst = 1'b0; n_grant = 0; n_dack = 0;
  endtask

  task automatic drain(input string nm);
    bit ok;
    if (bus.active === 1'b1) begin
      wait_ev(2, 100, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL %s_drain: active=%b required 0 within 100 cycles", nm, bus.active); end
    end
    cycle();
  endtask

  task automatic test_reset();
    bus.data = '0; bus.cfg_data = '0; uart_en = 1;
    do_reset();
    n_cmp++;
    if ({bus.send, bus.conf, bus.active, bus.cfg_ack, bus.err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctl: send/conf/active/cfg_ack/err=%b required 00000", {bus.send, bus.conf, bus.active, bus.cfg_ack, bus.err});
    end
    n_cmp++;
    if (bus.dpin !== 8'h00 || bus.ack !== '0 || bus.grant_id !== '0) begin
      n_bad++; $display("FAIL reset_data: dpin=%h ack=%b grant_id=%0d required 00/0000/0", bus.dpin, bus.ack, bus.grant_id);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    u_dly = 3; u_len = 4; bus.data[0] = 8'hA5; bus.req = 4'b0001;
    cycle();
    n_cmp++;
    if (bus.send !== 1'b1 || bus.active !== 1'b1 || bus.dpin !== 8'hA5 || bus.conf !== 1'b0) begin
      n_bad++; $display("FAIL single_latency: send=%b active=%b dpin=%h conf=%b required 1/1/a5/0", bus.send, bus.active, bus.dpin, bus.conf);
    end
    wait_ev(1, 30, ok);
    n_cmp++;
    if (!ok || bus.ack !== 4'b0001 || bus.send !== 1'b0) begin
      n_bad++; $display("FAIL single_ack: seen=%b ack=%b send=%b required ack=0001 send=0", ok, bus.ack, bus.send);
    end
    bus.req = '0;
    wait_ev(2, 30, ok);
    n_cmp++;
    if (!ok || ap_busy !== 1'b0) begin
      n_bad++; $display("FAIL single_done: active_fell=%b busy_seen=%b required 1/0", ok, ap_busy);
    end
    cycle();
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [N-1:0] ev;
    do_reset();
    u_dly = 2; u_len = 10;
    for (int i = 0; i < N; i++) bus.data[i] = bytes[i];
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ev(1, 60, ok);
      ev = '0; ev[exp_seq[k]] = 1'b1;
      if (k == 4) bus.req = '0;
      n_cmp++;
      if (!ok || bus.ack !== ev || bus.grant_id !== GW'(exp_seq[k]) || bus.dpin !== bytes[exp_seq[k]]) begin
        n_bad++; $display("FAIL rr_grant%0d: ack=%b grant_id=%0d dpin=%h required ack=%b grant_id=%0d dpin=%h", k, bus.ack, bus.grant_id, bus.dpin, ev, exp_seq[k], bytes[exp_seq[k]]);
      end
    end
    drain("rr");
  endtask

  task automatic test_cfg_priority();
    bit ok;
    do_reset();
    u_dly = 2; u_len = 3;
    bus.data[2] = 8'h77; bus.req = 4'b0100; bus.cfg_req = 1'b1; bus.cfg_data = 8'h3C;
    cycle();
    bus.cfg_req = 1'b0;
    n_cmp++;
    if (bus.send !== 1'b1 || bus.conf !== 1'b1 || bus.dpin !== 8'h3C) begin
      n_bad++; $display("FAIL cfg_first: send=%b conf=%b dpin=%h required 1/1/3c", bus.send, bus.conf, bus.dpin);
    end
    wait_ev(1, 30, ok);
    n_cmp++;
    if (!ok || bus.cfg_ack !== 1'b1 || bus.ack !== '0) begin
      n_bad++; $display("FAIL cfg_ack: cfg_ack=%b ack=%b required 1/0000", bus.cfg_ack, bus.ack);
    end
    wait_ev(0, 30, ok);
    n_cmp++;
    if (!ok || bus.conf !== 1'b0 || bus.dpin !== 8'h77 || bus.grant_id !== 2'd2) begin
      n_bad++; $display("FAIL cfg_then_data: conf=%b dpin=%h grant_id=%0d required 0/77/2", bus.conf, bus.dpin, bus.grant_id);
    end
    wait_ev(1, 30, ok);
    bus.req = '0;
    n_cmp++;
    if (!ok || bus.ack !== 4'b0100) begin
      n_bad++; $display("FAIL cfg_data_ack: ack=%b required 0100", bus.ack);
    end
    drain("cfg1");
    // another config between data grants must leave the rotation where it was
    bus.cfg_req = 1'b1; bus.cfg_data = 8'hC3;
    cycle();
    bus.cfg_req = 1'b0;
    drain("cfg2");
    bus.req = 4'b1011;
    wait_ev(0, 30, ok);
    n_cmp++;
    if (!ok || bus.grant_id !== 2'd3) begin
      n_bad++; $display("FAIL cfg_ptr: grant_id=%0d required 3", bus.grant_id);
    end
    bus.req = '0;
    drain("cfg3");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int acks = 0;
    do_reset();
    u_dly = 2; u_len = 12; bus.req = 4'b0010;
    wait_ev(1, 30, ok);
    bus.req = '0;
    cycle();
    rst = 1'b1;
    cycle();
    n_cmp++;
    if ({bus.send, bus.active, bus.conf, bus.cfg_ack} !== 4'b0 || bus.ack !== '0 || bus.grant_id !== '0 || bus.dpin !== 8'h00) begin
      n_bad++; $display("FAIL midrst_outputs: send=%b active=%b grant_id=%0d dpin=%h ack=%b required all zero", bus.send, bus.active, bus.grant_id, bus.dpin, bus.ack);
    end
    rst = 1'b0; bus.busy = 1'b0; u_phase = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.ack !== '0 || bus.cfg_ack !== 1'b0) acks++;
    end
    n_cmp++;
    if (acks != 0) begin n_bad++; $display("FAIL midrst_noack: acks=%0d required 0", acks); end
    bus.req = 4'b0011;
    wait_ev(0, 10, ok);
    n_cmp++;
    if (!ok || bus.grant_id !== 2'd0) begin
      n_bad++; $display("FAIL midrst_first: grant_id=%0d required 0", bus.grant_id);
    end
    bus.req = '0;
    drain("midrst");
  endtask

  task automatic test_drop_req();
    int acks = 0, rises = 0;
    logic [N-1:0] last_ack = '0;
    logic ps;
    do_reset();
    u_dly = 2; u_len = 3; bus.data[3] = 8'h5E; bus.req = 4'b1000;
    cycle();
    bus.req = '0; bus.data[3] = 8'hE5;
    for (int i = 0; i < 40; i++) begin
      ps = bus.send;
      cycle();
      if (bus.send === 1'b1 && ps !== 1'b1) rises++;
      if (bus.ack !== '0) begin acks++; last_ack = bus.ack; end
    end
    n_cmp++;
    if (acks != 1 || last_ack !== 4'b1000 || rises != 0) begin
      n_bad++; $display("FAIL drop_req: acks=%0d ack=%b regrants=%0d required 1/1000/0", acks, last_ack, rises);
    end
  endtask

  task automatic test_timeout();
    int cnt = 1;
    do_reset();
    uart_en = 0; bus.busy = 1'b0; bus.req = 4'b0010;
    cycle();
    bus.req = '0;
`ifdef UART_SCHED_TIMEOUT_EN
    begin
      bit ok;
      for (int i = 0; i < 40 && bus.send === 1'b1; i++) begin
        cycle();
        if (bus.send === 1'b1) cnt++;
      end
      n_cmp++;
      if (cnt != TMO || bus.err !== 1'b1 || bus.ack !== '0 || bus.active !== 1'b0) begin
        n_bad++; $display("FAIL timeout_abort: send_cycles=%0d err=%b ack=%b active=%b required %0d/1/0000/0", cnt, bus.err, bus.ack, bus.active, TMO);
      end
      cycle();
      n_cmp++;
      if (bus.err !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse: err=%b required 0", bus.err); end
      uart_en = 1; u_dly = 1; u_len = 2; u_phase = 0;
      bus.req = 4'b0011;
      wait_ev(0, 10, ok);
      n_cmp++;
      if (!ok || bus.grant_id !== 2'd0) begin
        n_bad++; $display("FAIL timeout_ptr: grant_id=%0d required 0", bus.grant_id);
      end
      bus.req = '0;
      drain("timeout");
    end
`else
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.send === 1'b1 && bus.err === 1'b0 && bus.ack === '0) cnt++;
    end
    n_cmp++;
    if (cnt != 41) begin
      n_bad++; $display("FAIL no_timeout: send-high cycles without err=%0d required 41", cnt);
    end
    uart_en = 1;
    do_reset();
`endif
    uart_en = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
      bus.cfg_req = ($urandom_range(0, 11) == 0);
      bus.cfg_data = 8'($urandom);
      for (int j = 0; j < N; j++) bus.data[j] = 8'($urandom);
      u_dly = $urandom_range(1, 4);
      u_len = $urandom_range(1, 6);
      cycle();
    end
    bus.req = '0; bus.cfg_req = 1'b0;
    drain("random");
    n_cmp++;
    if (pend || n_grant != n_dack || n_grant < 50) begin
      n_bad++; $display("FAIL random_balance: grants=%0d acks=%0d open=%b required equal, >=50, none open", n_grant, n_dack, pend);
    end
  endtask

  initial begin
    bus.req = '0; bus.data = '0; bus.cfg_req = 1'b0; bus.cfg_data = '0; bus.busy = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_cfg_priority();
    test_reset_mid();
    test_drop_req();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
